// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: handshakes loads/stores with a variable-latency data
// memory, stalls the upstream pipeline while an access is outstanding, feeds
// bubbles into MEM/WB until completion and aborts hung accesses via a watchdog.
module mem_stage_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [4:0]  WB_control_i,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        stall_o,
  output logic [4:0]  WB_control_o,
  output logic [31:0] ReadData_o,
  output logic        timeout_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      rdata_q,   rdata_d;
  logic             timeout_q, timeout_d;
  logic             abort_q,   abort_d;

  logic mem_op;
  logic is_load;

  // A request with both read and write set is treated as a store.
  assign mem_op  = mem_read_i | mem_write_i;
  assign is_load = mem_read_i & ~mem_write_i;

  // Next-state logic: access tracking, watchdog count, captured load data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    abort_d   = abort_q;
    case (state_q)
      S_IDLE: begin
        // Zero-wait accesses complete here without leaving IDLE.
        if (mem_op && !dmem_ready_i) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_ONE;
        end
      end
      S_ACCESS: begin
        // Memory completion wins over a watchdog expiry in the same cycle.
        if (dmem_ready_i) begin
          rdata_d = is_load ? dmem_rdata_i : '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          rdata_d   = '0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        // EX/MEM still holds the finished instruction, so never start here.
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      abort_q   <= abort_d;
    end
  end

  // Output decode; outputs are forced low while reset is held so an
  // in-flight request disappears immediately rather than at the next edge.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    stall_o      = 1'b0;
    WB_control_o = '0;
    ReadData_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          dmem_req_o = 1'b1;
          dmem_we_o  = mem_write_i;
          if (dmem_ready_i) begin
            WB_control_o = WB_control_i;
            ReadData_o   = is_load ? dmem_rdata_i : '0;
          end else begin
            stall_o = 1'b1;
          end
        end else begin
          WB_control_o = WB_control_i;
        end
      end
      S_ACCESS: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = mem_write_i;
        stall_o    = 1'b1;
      end
      S_DONE: begin
        ReadData_o   = rdata_q;
        WB_control_o = abort_q ? 5'b0 : WB_control_i;
      end
      default: begin
        dmem_req_o = 1'b0;
      end
    endcase
    if (!RESET) begin
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      stall_o      = 1'b0;
      WB_control_o = '0;
      ReadData_o   = '0;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Scoreboard bench for mem_stage_sequencer: a driver plays EX/MEM instructions
// and a memory with a chosen wait count, pushing the per-cycle expected MEM
// stage response; a negedge monitor pops and compares.
module tb_mem_stage_sequencer;

  localparam int TO = 4;

  logic        CLK;
  logic        RESET;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [4:0]  WB_control_i;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        stall_o;
  logic [4:0]  WB_control_o;
  logic [31:0] ReadData_o;
  logic        timeout_o;

  mem_stage_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i),
    .WB_control_i(WB_control_i),
    .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i),
    .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o),
    .stall_o(stall_o),
    .WB_control_o(WB_control_o),
    .ReadData_o(ReadData_o),
    .timeout_o(timeout_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        req;
    logic        we;
    logic        chk_we;
    logic        stall;
    logic [4:0]  wb;
    logic [31:0] rd;
    logic        chk_rd;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  logic mon_en   = 1'b0;
  logic tmo_model = 1'b0;
  int   cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle=%0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle while enabled.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow cycle=%0d: got empty queue expected an entry", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("req", 32'(dmem_req_o), 32'(mon_e.req));
        if (mon_e.chk_we) check("we", 32'(dmem_we_o), 32'(mon_e.we));
        check("stall", 32'(stall_o), 32'(mon_e.stall));
        check("wb", 32'(WB_control_o), 32'(mon_e.wb));
        if (mon_e.chk_rd) check("rdata", ReadData_o, mon_e.rd);
        check("timeout", 32'(timeout_o), 32'(mon_e.tmo));
      end
    end
  end

  // kind: 0 ALU, 1 load, 2 store, 3 read+write (acts as store).
  // waits: memory wait cycles; ready on request cycle waits+1 unless that
  // exceeds the watchdog window of TO+1 request cycles.
  task automatic run_instr(input int kind, input logic [4:0] wb, input int waits,
                           input logic [31:0] fix, input bit use_fix);
    logic        op, wr_op, abort;
    logic [31:0] data, cap;
    int          total;
    exp_t        e;
    op    = (kind != 0);
    wr_op = (kind >= 2);
    abort = op && (waits > TO);
    if (!op || waits == 0) total = 1;
    else if (abort)        total = TO + 2;
    else                   total = waits + 2;
    cap = '0;
    for (int k = 0; k < total; k++) begin
      data = $urandom;
      if (use_fix && k == waits) data = fix;
      mem_read_i   = (kind == 1) || (kind == 3);
      mem_write_i  = wr_op;
      WB_control_i = wb;
      dmem_rdata_i = data;
      dmem_ready_i = op && !abort && (k == waits);
      if (k == waits && kind == 1) cap = data;
      e = '{default: '0};
      if (!op) begin
        e.wb = wb; e.chk_rd = 1'b1; e.rd = '0;
      end else if (waits == 0) begin
        e.req = 1'b1; e.we = wr_op; e.chk_we = 1'b1; e.wb = wb;
        e.chk_rd = 1'b1; e.rd = (kind == 1) ? data : 32'h0;
      end else if (k < total - 1) begin
        e.req = 1'b1; e.we = wr_op; e.chk_we = 1'b1; e.stall = 1'b1; e.wb = 5'b0;
      end else begin
        if (abort) tmo_model = 1'b1;
        e.wb = abort ? 5'b0 : wb;
        e.chk_rd = 1'b1;
        e.rd = abort ? 32'h0 : cap;
      end
      e.tmo = tmo_model;
      exp_q.push_back(e);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got no end of test expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  initial begin
    int r, kind, waits;
    RESET = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; WB_control_i = '0;
    dmem_ready_i = 1'b0; dmem_rdata_i = '0;
    #12;
    check("rst_req",     32'(dmem_req_o),   32'h0);
    check("rst_we",      32'(dmem_we_o),    32'h0);
    check("rst_stall",   32'(stall_o),      32'h0);
    check("rst_wb",      32'(WB_control_o), 32'h0);
    check("rst_rdata",   ReadData_o,        32'h0);
    check("rst_timeout", 32'(timeout_o),    32'h0);
    #5 RESET = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    run_instr(1, 5'b01100, 0, 32'hDEADBEEF, 1'b1);
    run_instr(1, 5'b01101, 3, 32'h12345678, 1'b1);
    run_instr(2, 5'b00011, 2, 32'h0, 1'b0);
    run_instr(3, 5'b00010, 2, 32'h0, 1'b0);
    run_instr(0, 5'b01001, 0, 32'h0, 1'b0);
    run_instr(1, 5'b01110, 4, 32'hA5A5_5A5A, 1'b1);
    run_instr(1, 5'b01100, 5, 32'h0, 1'b0);
    run_instr(1, 5'b01000, 1, 32'h0BAD_F00D, 1'b1);
    run_instr(1, 5'b01111, 1, 32'h1357_9BDF, 1'b1);
    run_instr(2, 5'b00001, 0, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      if (r < 3)      waits = 0;
      else if (r < 8) waits = r - 2;
      else            waits = $urandom_range(TO + 1, TO + 2);
      run_instr(kind, 5'($urandom), waits, 32'h0, 1'b0);
    end

    // Reset in the middle of a pending access.
    mon_en = 1'b0;
    mem_read_i = 1'b1; mem_write_i = 1'b0; WB_control_i = 5'b01100;
    dmem_ready_i = 1'b0; dmem_rdata_i = $urandom;
    @(posedge CLK); #1;
    check("access_req",   32'(dmem_req_o), 32'h1);
    check("access_stall", 32'(stall_o),    32'h1);
    check("pre_rst_tmo",  32'(timeout_o),  32'(tmo_model));
    #2 RESET = 1'b0;
    #1;
    check("midrst_req",     32'(dmem_req_o),   32'h0);
    check("midrst_stall",   32'(stall_o),      32'h0);
    check("midrst_wb",      32'(WB_control_o), 32'h0);
    check("midrst_timeout", 32'(timeout_o),    32'h0);
    @(posedge CLK); #1;
    mem_read_i = 1'b0;
    check("held_rst_req", 32'(dmem_req_o), 32'h0);
    #2 RESET = 1'b1;
    tmo_model = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    run_instr(0, 5'b01010, 0, 32'h0, 1'b0);
    run_instr(1, 5'b01100, 0, 32'hCAFE_0001, 1'b1);
    run_instr(2, 5'b00011, 1, 32'h0, 1'b0);
    mon_en = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
